pipe_stage_reg: RTL and testbench

//  Generic inter-stage pipeline register for the ARM core (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 153 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid/ready, flush and freeze
// The control field is zeroed whenever no entry is held, so a bubble always reads as a NOP.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (SKID == 0) begin : g_single
      logic              valid_q, valid_d;
      logic [CTRL_W-1:0] ctrl_q, ctrl_d;
      logic [DATA_W-1:0] data_q, data_d;
      logic              push, pop;

      assign in_ready  = (~valid_q | out_ready) & ~freeze;
      assign push      = in_valid & in_ready;
      assign pop       = valid_q & out_ready;
      assign out_valid = valid_q;
      assign out_ctrl  = ctrl_q;
      assign out_data  = data_q;

      always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
          valid_d = 1'b0;
          ctrl_d  = '0;
        end else if (push) begin
          valid_d = 1'b1;
          ctrl_d  = in_ctrl;
          data_d  = in_data;
        end else if (pop) begin
          valid_d = 1'b0;
          ctrl_d  = '0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          ctrl_q  <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          ctrl_q  <= ctrl_d;
          data_q  <= data_d;
        end
      end
    end else begin : g_skid
      typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

      state_t            state_q, state_d;
      logic              rdy_q, rdy_d;
      logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
      logic [DATA_W-1:0] main_data_q, main_data_d;
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;
      logic              push, pop;

      // in_ready comes straight from a flop so upstream never sees the downstream ready path
      assign in_ready  = rdy_q & ~freeze;
      assign push      = in_valid & in_ready;
      assign out_valid = (state_q != ST_EMPTY);
      assign pop       = out_valid & out_ready;
      assign out_ctrl  = main_ctrl_q;
      assign out_data  = main_data_q;

      always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (push) begin
                state_d     = ST_ONE;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
              end
            end
            ST_ONE: begin
              if (push && pop) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
              end else if (pop) begin
                state_d     = ST_EMPTY;
                main_ctrl_d = '0;
              end else if (push) begin
                state_d     = ST_FULL;
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
              end
            end
            ST_FULL: begin
              if (pop) begin
                state_d     = ST_ONE;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_ctrl_d = '0;
              end
            end
            default: begin
              state_d     = ST_EMPTY;
              main_ctrl_d = '0;
              skid_ctrl_d = '0;
            end
          endcase
        end
        rdy_d = (state_d != ST_FULL);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q     <= ST_EMPTY;
          rdy_q       <= 1'b1;
          main_ctrl_q <= '0;
          main_data_q <= '0;
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
        end else begin
          state_q     <= state_d;
          rdy_q       <= rdy_d;
          main_ctrl_q <= main_ctrl_d;
          main_data_q <= main_data_d;
          skid_ctrl_q <= skid_ctrl_d;
          skid_data_q <= skid_data_d;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - bench for pipe_stage_reg, SKID=0 and SKID=1 side by side
// Both instances see the same stimulus; each has its own FIFO scoreboard of pushed entries.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         freeze = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_ctrl = '0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         rdy [2];
  logic         vld [2];
  logic [7:0]   ctl [2];
  logic [127:0] dat [2];

  logic [135:0] sb0[$];
  logic [135:0] sb1[$];

  int checks = 0;
  int failures = 0;
  int seq = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(vld[0]), .out_ready(out_ready), .out_ctrl(ctl[0]), .out_data(dat[0])
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(vld[1]), .out_ready(out_ready), .out_ctrl(ctl[1]), .out_data(dat[1])
  );

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already applied; checks, updates model, advances a cycle.
  task automatic step();
    logic [135:0] h;
    int           sz;
    logic         er;
    logic         pop;
    logic         push;
    #1;
    for (int k = 0; k < 2; k++) begin
      sz = (k == 0) ? sb0.size() : sb1.size();
      if (k == 1) er = (sz < 2) && !freeze;
      else        er = ((sz == 0) || out_ready) && !freeze;
      chk_eq($sformatf("in_ready%0d", k), {127'd0, rdy[k]}, {127'd0, er});
      chk_eq($sformatf("out_valid%0d", k), {127'd0, vld[k]}, {127'd0, (sz > 0)});
      if (sz > 0) begin
        h = (k == 0) ? sb0[0] : sb1[0];
        chk_eq($sformatf("out_ctrl%0d", k), {120'd0, ctl[k]}, {120'd0, h[135:128]});
        chk_eq($sformatf("out_data%0d", k), dat[k], h[127:0]);
      end else begin
        chk_eq($sformatf("bubble_ctrl%0d", k), {120'd0, ctl[k]}, 128'd0);
      end
      if (flush) begin
        if (k == 0) sb0.delete(); else sb1.delete();
      end else begin
        pop  = (sz > 0) && out_ready;
        push = in_valid && er;
        if (k == 0) begin
          if (pop)  void'(sb0.pop_front());
          if (push) sb0.push_back({in_ctrl, in_data});
        end else begin
          if (pop)  void'(sb1.pop_front());
          if (push) sb1.push_back({in_ctrl, in_data});
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic ordy,
                       input logic frz, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = {96'd0, 32'(seq)};
    seq++;
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
    step();
  endtask

  // Async reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_eq($sformatf("rst_valid%0d", k), {127'd0, vld[k]}, 128'd0);
      chk_eq($sformatf("rst_ctrl%0d", k), {120'd0, ctl[k]}, 128'd0);
      chk_eq($sformatf("rst_data%0d", k), dat[k], 128'd0);
    end
    sb0.delete();
    sb1.delete();
    in_valid = 1'b0; flush = 1'b0; freeze = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // streaming with ctrl A5
    for (int i = 0; i < 10; i++) drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // mid-stream reset
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // backpressure: fill, then a third entry waits upstream, then drain
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // flush while full, with a same-cycle push that must be dropped
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // freeze: hold one entry, drain under freeze, then resume
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 65);
      in_ctrl   = 8'($urandom());
      in_data   = {$urandom(), $urandom(), $urandom(), 32'(seq)};
      seq++;
      out_ready = ($urandom_range(0, 99) < 60);
      freeze    = ($urandom_range(0, 99) < 10);
      flush     = ($urandom_range(0, 99) < 5);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
